// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued long-latency results.
// Optional anti-starvation force path enabled by defining WB_ARB_ANTI_STARVE_EN.
module wb_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pipe_valid_i,
    input  logic [AW-1:0] pipe_rd_i,
    input  logic [DW-1:0] pipe_data_i,
    output logic          pipe_stall_o,
    input  logic          lu_valid_i,
    input  logic [AW-1:0] lu_rd_i,
    input  logic [DW-1:0] lu_data_i,
    output logic          lu_ready_o,
    output logic          lu_busy_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_rd_o,
    output logic [DW-1:0] rf_data_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          force_lu;
    logic          grant_lu;
    logic          grant_pipe;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;
    logic          sel_we;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

`ifdef WB_ARB_ANTI_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;

    // Cycles the current head has waited without being granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt < SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign force_lu = !empty && (starve_cnt >= SW'(STARVE_MAX));
`else
    logic unused_starve_max;

    assign unused_starve_max = (STARVE_MAX != 0);
    assign force_lu          = 1'b0;
`endif

    assign grant_lu     = force_lu || (!pipe_valid_i && !empty);
    assign grant_pipe   = pipe_valid_i && !force_lu;
    assign pop          = grant_lu;
    assign push         = lu_valid_i && !full;
    assign pipe_stall_o = force_lu;
    assign lu_ready_o   = !full;
    assign lu_busy_o    = !empty;

    // Writer select; x0 destinations consume the slot but never write.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (grant_lu) begin
            sel_rd   = mem_rd[rd_ptr];
            sel_data = mem_data[rd_ptr];
        end else if (grant_pipe) begin
            sel_rd   = pipe_rd_i;
            sel_data = pipe_data_i;
        end
        sel_we = (grant_lu || grant_pipe) && (sel_rd != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_o   <= 1'b0;
            rf_rd_o   <= '0;
            rf_data_o <= '0;
        end else begin
            rf_we_o   <= sel_we;
            rf_rd_o   <= sel_we ? sel_rd : '0;
            rf_data_o <= sel_we ? sel_data : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lu_rd_i;
            mem_data[wr_ptr] <= lu_data_i;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow WB_ARB_ANTI_STARVE_EN.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        pipe_stall;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        lu_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(2), .STARVE_MAX(4), .AW(5), .DW(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pipe_valid_i (pipe_valid),
        .pipe_rd_i    (pipe_rd),
        .pipe_data_i  (pipe_data),
        .pipe_stall_o (pipe_stall),
        .lu_valid_i   (lu_valid),
        .lu_rd_i      (lu_rd),
        .lu_data_i    (lu_data),
        .lu_ready_o   (lu_ready),
        .lu_busy_o    (lu_busy),
        .rf_we_o      (rf_we),
        .rf_rd_o      (rf_rd),
        .rf_data_o    (rf_data)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        total++; if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf got=%0d/%h exp=0/0", rf_rd, rf_data); end
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", pipe_stall); end
        total++; if (lu_ready !== 1'b1 || lu_busy !== 1'b0) begin bad++; $display("FAIL reset_lu got=rdy%b busy%b exp=rdy1 busy0", lu_ready, lu_busy); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pipe();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        #1;
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall); end
        tick();
        pipe_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_rd, rf_data);
        end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL pipe_idle got=%b exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            pipe_valid = 1'b1; pipe_rd = 5'(i); pipe_data = 32'h100 + 32'(i);
            tick();
            total++; if (rf_we !== 1'b1 || rf_rd !== 5'(i) || rf_data !== 32'h100 + 32'(i)) begin
                bad++; $display("FAIL b2b_%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_rd, rf_data, i, 32'h100 + 32'(i));
            end
        end
        pipe_valid = 1'b0;
        tick();
    endtask

    task automatic test_lu_idle();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h00001234;
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL lu_ready got=%b exp=1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        total++; if (lu_busy !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL lu_n1 got=busy%b we%b exp=busy1 we0", lu_busy, rf_we); end
        tick();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h00001234) begin
            bad++; $display("FAIL lu_write got=%b/%0d/%h exp=1/7/00001234", rf_we, rf_rd, rf_data);
        end
        total++; if (lu_busy !== 1'b0) begin bad++; $display("FAIL lu_busy_fall got=%b exp=0", lu_busy); end
        tick();
    endtask

    task automatic test_starve();
        logic exp_stall;
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        tick();
        lu_valid = 1'b0;
`ifdef WB_ARB_ANTI_STARVE_EN
        for (int i = 1; i <= 6; i++) begin
            #1;
            exp_stall = (i == 5);
            total++; if (pipe_stall !== exp_stall) begin bad++; $display("FAIL starve_stall_c%0d got=%b exp=%b", i, pipe_stall, exp_stall); end
            if (i == 6) begin
                total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99) begin
                    bad++; $display("FAIL starve_lu_write got=%b/%0d/%h exp=1/9/99", rf_we, rf_rd, rf_data);
                end
            end
            tick();
        end
        total++; if (rf_rd !== 5'd3 || lu_busy !== 1'b0) begin bad++; $display("FAIL starve_after got=rd%0d busy%b exp=rd3 busy0", rf_rd, lu_busy); end
        pipe_valid = 1'b0;
        tick();
`else
        for (int i = 1; i <= 6; i++) begin
            #1;
            exp_stall = 1'b0;
            total++; if (pipe_stall !== exp_stall || rf_rd !== 5'd3) begin
                bad++; $display("FAIL starve_wait_c%0d got=stall%b rd%0d exp=stall0 rd3", i, pipe_stall, rf_rd);
            end
            tick();
        end
        pipe_valid = 1'b0;
        total++; if (lu_busy !== 1'b1) begin bad++; $display("FAIL starve_busy got=%b exp=1", lu_busy); end
        tick();
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99) begin
            bad++; $display("FAIL starve_lu_write got=%b/%0d/%h exp=1/9/99", rf_we, rf_rd, rf_data);
        end
        total++; if (lu_busy !== 1'b0) begin bad++; $display("FAIL starve_busy_fall got=%b exp=0", lu_busy); end
`endif
        tick();
    endtask

    task automatic test_full();
        pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h22;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA;
        tick();
        lu_rd = 5'd11; lu_data = 32'hB;
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL full_rdy1 got=%b exp=1", lu_ready); end
        tick();
        lu_rd = 5'd12; lu_data = 32'hC;
        #1;
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL full_rdy_n2 got=%b exp=0", lu_ready); end
        tick();
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL full_rdy_n3 got=%b exp=0", lu_ready); end
        tick();
        pipe_valid = 1'b0;
        #1;
        total++; if (lu_ready !== 1'b0) begin bad++; $display("FAIL full_no_pushthrough got=%b exp=0", lu_ready); end
        tick();
        #1;
        total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL full_rdy_n5 got=%b exp=1", lu_ready); end
        total++; if (rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_data !== 32'hA) begin
            bad++; $display("FAIL full_drain_a got=%b/%0d/%h exp=1/10/a", rf_we, rf_rd, rf_data);
        end
        tick();
        lu_valid = 1'b0;
        total++; if (rf_rd !== 5'd11 || rf_data !== 32'hB) begin bad++; $display("FAIL full_drain_b got=%0d/%h exp=11/b", rf_rd, rf_data); end
        tick();
        total++; if (rf_rd !== 5'd12 || rf_data !== 32'hC) begin bad++; $display("FAIL full_drain_c got=%0d/%h exp=12/c", rf_rd, rf_data); end
        tick();
        total++; if (rf_we !== 1'b0 || lu_busy !== 1'b0) begin bad++; $display("FAIL full_empty got=we%b busy%b exp=we0 busy0", rf_we, lu_busy); end
    endtask

    task automatic test_x0();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFFFFFF;
        tick();
        pipe_valid = 1'b0;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h5555;
        total++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
            bad++; $display("FAIL x0_pipe got=%b/%0d/%h exp=0/0/0", rf_we, rf_rd, rf_data);
        end
        tick();
        lu_valid = 1'b0;
        total++; if (lu_busy !== 1'b1) begin bad++; $display("FAIL x0_lu_busy got=%b exp=1", lu_busy); end
        tick();
        total++; if (rf_we !== 1'b0 || rf_data !== 32'd0 || lu_busy !== 1'b0) begin
            bad++; $display("FAIL x0_lu got=we%b data%h busy%b exp=we0 data0 busy0", rf_we, rf_data, lu_busy);
        end
    endtask

    task automatic test_reset_mid();
        pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h44;
        lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h66;
        tick();
        lu_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || lu_busy !== 1'b1) begin bad++; $display("FAIL rmid_pre got=we%b busy%b exp=we1 busy1", rf_we, lu_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || pipe_stall !== 1'b0) begin bad++; $display("FAIL rmid_async got=we%b stall%b exp=we0 stall0", rf_we, pipe_stall); end
        total++; if (lu_ready !== 1'b1 || lu_busy !== 1'b0) begin bad++; $display("FAIL rmid_lu got=rdy%b busy%b exp=rdy1 busy0", lu_ready, lu_busy); end
        pipe_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rf_we !== 1'b0 || lu_busy !== 1'b0) begin bad++; $display("FAIL rmid_stale_c%0d got=we%b busy%b exp=we0 busy0", i, rf_we, lu_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_back_to_back();
        test_lu_idle();
        test_starve();
        test_full();
        test_x0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
